// File: rtl/adc_max10_seq_core.sv
// rtl/adc_max10_seq_core.sv - register-mapped channel-scan sequencer for the MAX10 Modular ADC core
module adc_max10_seq_core #(
    parameter int ADDR_WIDTH = 4,
    parameter int CH_COUNT   = 8
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [31:0]           write_data,
    input  logic                  write_enable,
    output logic                  ADC_C_Valid,
    output logic [4:0]            ADC_C_Channel,
    output logic                  ADC_C_SOP,
    output logic                  ADC_C_EOP,
    input  logic                  ADC_C_Ready,
    input  logic                  ADC_R_Valid,
    input  logic [4:0]            ADC_R_Channel,
    input  logic [11:0]           ADC_R_Data,
    input  logic                  ADC_R_SOP,
    input  logic                  ADC_R_EOP,
    input  logic                  ADC_Trigger,
    output logic                  ADC_Interrupt
);
    localparam int CW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int PW = CW + 1;

    typedef enum logic [1:0] {IDLE, SELECT, CMD, WAIT} state_t;

    state_t                state, next_state;
    logic                  en, sc, te, ie, iflag;
    logic [CH_COUNT-1:0]   mask;
    logic [11:0]           data [CH_COUNT];
    logic [PW-1:0]         ptr, ptr_d;
    logic [CW-1:0]         chan, chan_d, sel;
    logic                  found, scan_done, conv;
    logic                  trig_s1, trig_s2, trig_s3;
    logic                  wr_adcs, wr_mask, en_off, trig_set, sw_set;
    logic                  unused;

    // Response packet framing is not needed: one command yields one sample.
    assign unused = ^{ADC_R_SOP, ADC_R_EOP, write_data};

    assign wr_adcs  = write_enable && (write_addr == ADDR_WIDTH'(0));
    assign wr_mask  = write_enable && (write_addr == ADDR_WIDTH'(1));
    assign en_off   = wr_adcs && !write_data[0];
    assign trig_set = trig_s2 && !trig_s3 && en && te && !sc;
    assign sw_set   = wr_adcs && write_data[1] && write_data[0];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            if (mask[i] && (PW'(i) >= ptr)) begin
                found = 1'b1;
                sel   = CW'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            ptr   <= '0;
            chan  <= '0;
        end else begin
            state <= next_state;
            ptr   <= ptr_d;
            chan  <= chan_d;
        end
    end

    always_comb begin
        next_state = state;
        ptr_d      = ptr;
        chan_d     = chan;
        scan_done  = 1'b0;
        conv       = 1'b0;
        case (state)
            IDLE: begin
                if (sc) begin
                    next_state = SELECT;
                    ptr_d      = '0;
                end
            end
            SELECT: begin
                if (found) begin
                    chan_d     = sel;
                    next_state = CMD;
                end else begin
                    scan_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            CMD: begin
                if (ADC_C_Ready) next_state = WAIT;
            end
            WAIT: begin
                if (ADC_R_Valid && (ADC_R_Channel == 5'(chan))) begin
                    conv       = 1'b1;
                    ptr_d      = PW'(chan) + PW'(1);
                    next_state = SELECT;
                end
            end
            default: next_state = IDLE;
        endcase
        // Disabling aborts the scan outright; no completion, no sample capture.
        if (en_off) begin
            next_state = IDLE;
            scan_done  = 1'b0;
            conv       = 1'b0;
        end
    end

    assign ADC_C_Valid   = (state == CMD);
    assign ADC_C_SOP     = (state == CMD);
    assign ADC_C_EOP     = (state == CMD);
    assign ADC_C_Channel = (state == CMD) ? 5'(chan) : 5'd0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            en            <= 1'b0;
            sc            <= 1'b0;
            te            <= 1'b0;
            ie            <= 1'b0;
            iflag         <= 1'b0;
            mask          <= '0;
            trig_s1       <= 1'b0;
            trig_s2       <= 1'b0;
            trig_s3       <= 1'b0;
            ADC_Interrupt <= 1'b0;
        end else begin
            trig_s1       <= ADC_Trigger;
            trig_s2       <= trig_s1;
            trig_s3       <= trig_s2;
            ADC_Interrupt <= iflag && ie;
            if (wr_adcs) begin
                en <= write_data[0];
                te <= write_data[2];
                ie <= write_data[3];
            end
            if (wr_mask) mask <= write_data[CH_COUNT-1:0];
            if (en_off || scan_done) sc <= 1'b0;
            else if (trig_set || sw_set) sc <= 1'b1;
            if (scan_done) iflag <= 1'b1;
            else if (wr_adcs && !write_data[4]) iflag <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < CH_COUNT; i++) data[i] <= '0;
        end else if (conv) begin
            data[chan] <= ADC_R_Data;
        end
    end

    always_comb begin
        read_data = '0;
        if (read_addr == ADDR_WIDTH'(0)) read_data = {27'd0, iflag, ie, te, sc, en};
        else if (read_addr == ADDR_WIDTH'(1)) read_data = 32'(mask);
        for (int i = 0; i < CH_COUNT; i++) begin
            if (read_addr == ADDR_WIDTH'(i + 2)) read_data = {20'd0, data[i]};
        end
    end
endmodule

// File: tb/tb_adc_max10_seq_core.sv
// tb/tb_adc_max10_seq_core.sv - directed self-checking bench for adc_max10_seq_core
module tb_adc_max10_seq_core;
    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [3:0]  read_addr = '0;
    logic [31:0] read_data;
    logic [3:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        ADC_C_Valid;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_SOP;
    logic        ADC_C_EOP;
    logic        ADC_C_Ready = 1'b0;
    logic        ADC_R_Valid = 1'b0;
    logic [4:0]  ADC_R_Channel = '0;
    logic [11:0] ADC_R_Data = '0;
    logic        ADC_R_SOP = 1'b0;
    logic        ADC_R_EOP = 1'b0;
    logic        ADC_Trigger = 1'b0;
    logic        ADC_Interrupt;

    int compared = 0;
    int mismatched = 0;

    adc_max10_seq_core #(.ADDR_WIDTH(4), .CH_COUNT(8)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .read_addr(read_addr), .read_data(read_data),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
        .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
        .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
        .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
        .ADC_Trigger(ADC_Trigger), .ADC_Interrupt(ADC_Interrupt)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        read_addr = addr;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] val);
        write_addr = addr;
        write_data = val;
        write_enable = 1'b1;
        tick(1);
        write_enable = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !ADC_C_Valid; i++) tick(1);
        check(tag, 32'(ADC_C_Valid), 32'd1);
    endtask

    task automatic take_cmd(input string tag, input logic [4:0] ch);
        wait_valid({tag, "_seen"});
        check({tag, "_chan"}, 32'(ADC_C_Channel), 32'(ch));
        check({tag, "_sopeop"}, {30'd0, ADC_C_SOP, ADC_C_EOP}, 32'd3);
        tick(2);
        check({tag, "_held"}, {26'd0, ADC_C_Valid, ADC_C_Channel}, {26'd0, 1'b1, ch});
        ADC_C_Ready = 1'b1;
        tick(1);
        ADC_C_Ready = 1'b0;
        check({tag, "_dropped"}, 32'(ADC_C_Valid), 32'd0);
    endtask

    task automatic respond(input logic [4:0] ch, input logic [11:0] d);
        tick(1);
        ADC_R_Valid = 1'b1;
        ADC_R_Channel = ch;
        ADC_R_Data = d;
        tick(1);
        ADC_R_Valid = 1'b0;
    endtask

    initial begin
        tick(2);
        RESETn = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) rd($sformatf("reset_reg%0d", i), 4'(i), 32'd0);
        check("reset_valid", 32'(ADC_C_Valid), 32'd0);
        check("reset_irq", 32'(ADC_Interrupt), 32'd0);

        // software-started single-channel scan
        wr(1, 32'h02);
        rd("mask_rb", 1, 32'h02);
        wr(0, 32'h0F);
        take_cmd("sc_cmd1", 5'd1);
        respond(5'd3, 12'h111);
        rd("other_ch_ignored", 5, 32'd0);
        respond(5'd1, 12'hABC);
        tick(2);
        rd("adc1", 3, 32'h0ABC);
        rd("adcs_done", 0, 32'h1D);
        check("irq_set", 32'(ADC_Interrupt), 32'd1);

        // trigger-started two-channel scan, IE off
        wr(0, 32'h05);
        wr(1, 32'h05);
        tick(2);
        check("irq_off_ie0", 32'(ADC_Interrupt), 32'd0);
        ADC_Trigger = 1'b1;
        tick(3);
        ADC_Trigger = 1'b0;
        take_cmd("te_cmd0", 5'd0);
        respond(5'd0, 12'h123);
        take_cmd("te_cmd2", 5'd2);
        respond(5'd2, 12'h456);
        tick(3);
        rd("adcs_te_done", 0, 32'h15);
        check("irq_ie0", 32'(ADC_Interrupt), 32'd0);
        rd("adc0", 2, 32'h123);
        rd("adc2", 4, 32'h456);
        rd("adc1_kept", 3, 32'hABC);

        // IF clear with IE set, then SC with EN=0
        wr(0, 32'h19);
        tick(2);
        check("irq_ie1", 32'(ADC_Interrupt), 32'd1);
        wr(0, 32'h09);
        tick(2);
        check("irq_cleared", 32'(ADC_Interrupt), 32'd0);
        rd("adcs_if_clr", 0, 32'h09);
        wr(0, 32'h02);
        tick(5);
        check("no_cmd_en0", 32'(ADC_C_Valid), 32'd0);
        rd("sc_en0", 0, 32'h00);

        // empty mask
        wr(1, 32'h00);
        wr(0, 32'h0B);
        tick(2);
        rd("empty_mask_adcs", 0, 32'h19);
        check("empty_no_cmd", 32'(ADC_C_Valid), 32'd0);
        tick(1);
        check("empty_irq", 32'(ADC_Interrupt), 32'd1);

        // abort mid-scan by clearing EN
        wr(0, 32'h01);
        wr(1, 32'h10);
        wr(0, 32'h03);
        wait_valid("abort_cmd_seen");
        check("abort_chan", 32'(ADC_C_Channel), 32'd4);
        wr(0, 32'h00);
        check("abort_valid_drop", 32'(ADC_C_Valid), 32'd0);
        respond(5'd4, 12'h777);
        tick(2);
        rd("abort_adc4", 6, 32'd0);
        rd("abort_adcs", 0, 32'd0);
        check("abort_no_recmd", 32'(ADC_C_Valid), 32'd0);

        // reset mid-scan
        wr(1, 32'h02);
        wr(0, 32'h03);
        wait_valid("rst_cmd_seen");
        #2 RESETn = 1'b0;
        #1;
        check("rst_valid", 32'(ADC_C_Valid), 32'd0);
        rd("rst_adc1", 3, 32'd0);
        rd("rst_adcs", 0, 32'd0);
        rd("rst_mask", 1, 32'd0);
        tick(1);
        RESETn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/adc_max10_seq_core.md
Name: adc_max10_seq_core

Overview:
- Register-mapped sequencer for the MAX10 on-chip ADC (Modular ADC core, Avalon-ST command/response interface).
- Software selects channels through a mask, then starts a scan by software (SC) or by an external trigger (TE).
- Each masked channel is converted in ascending order and its 12-bit result is stored in a per-channel data register.
- Raises an interrupt at end of scan. Sits behind a simple bus-to-register bridge (AHB-Lite wrapper).

Parameters:
- ADDR_WIDTH, 4, register address width.
- CH_COUNT, 8, number of logical channels (mask bits, data registers); channel index equals ADC channel number.

Ports:
- CLK  in  1  system clock; also the ADC core clock_clk.
- RESETn  in  1  asynchronous active-low reset.
- read_addr  in  ADDR_WIDTH  register read address.
- read_data  out  32  register read data, combinational from read_addr.
- write_addr  in  ADDR_WIDTH  register write address.
- write_data  in  32  register write data.
- write_enable  in  1  write strobe, sampled at posedge CLK.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel.
- ADC_C_SOP  out  1  command start of packet.
- ADC_C_EOP  out  1  command end of packet.
- ADC_C_Ready  in  1  command accepted.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  response sample.
- ADC_R_SOP  in  1  response start of packet (ignored).
- ADC_R_EOP  in  1  response end of packet (ignored).
- ADC_Trigger  in  1  asynchronous external start trigger.
- ADC_Interrupt  out  1  level interrupt.

Behaviour:
- Register map:
  - 0 = ADCS (control/status).
  - 1 = ADMSK (bits CH_COUNT-1:0, bit n enables channel n).
  - 2+n = ADCn (result in bits 11:0, upper bits 0, read-only).
  - Unmapped reads return 0; unmapped writes are ignored.
- ADCS fields, all other bits read 0:
  - bit0 EN: enable.
  - bit1 SC: start/busy.
  - bit2 TE: trigger enable.
  - bit3 IE: interrupt enable.
  - bit4 IF: interrupt flag.
- Reset: all registers 0, FSM IDLE, ADC_C_Valid/SOP/EOP=0, ADC_C_Channel=0, ADC_Interrupt=0.
- Register writes take effect at the posedge where write_enable=1. read_data reflects the new value from the following cycle.
- ADCS write:
  - EN, TE, IE are loaded directly.
  - SC: writing 1 sets it when EN=1 (or EN is being written 1); writing 0 is ignored while busy.
  - IF: writing 0 clears it; writing 1 is ignored.
- Trigger: ADC_Trigger passes through a 2-FF synchronizer. A rising edge with EN=1 and TE=1 sets SC. If SC is already 1, the trigger is ignored.
- Hardware set/clear of SC and IF wins over a same-cycle software write to the same bit.
- FSM IDLE:
  - SC=1 moves to SELECT with search pointer = 0.
- FSM SELECT:
  - Find the lowest masked channel >= pointer (ADMSK sampled at this point).
  - None found: clear SC, set IF, go to IDLE.
  - Found: go to CMD.
- FSM CMD:
  - Drive ADC_C_Valid=1, ADC_C_SOP=1, ADC_C_EOP=1, ADC_C_Channel=channel.
  - Hold all of these until ADC_C_Ready=1 in the same cycle, then deassert and go to WAIT.
- FSM WAIT:
  - On ADC_R_Valid=1 with ADC_R_Channel==channel: write ADC_R_Data into ADCn, set pointer=channel+1, go to SELECT.
  - Responses with another channel are ignored.
- Empty mask with SC set: scan finishes in SELECT immediately; SC clears and IF sets within 2 cycles.
- EN written 0 in any state: FSM returns to IDLE next cycle, ADC_C_Valid drops, SC clears, a pending response is discarded, IF unchanged.
- ADC_Interrupt = IF & IE, registered output, 1-cycle lag.
- Data registers keep their last value until overwritten by a new conversion or reset.
- Asserting RESETn low mid-scan returns everything to reset values immediately.

Test Plan:
- Reset, then read all registers -> all 0; ADC_C_Valid=0, ADC_Interrupt=0.
- Write ADMSK=0x02, read ADMSK -> 0x00000002. Write ADCS=0x0F -> one command with channel 1, SOP=EOP=1, held until Ready. Response 0xABC on channel 1 -> ADC1=0x00000ABC, then ADCS reads 0x1D (SC clear, IF set), ADC_Interrupt=1.
- Write ADCS=0x05 (EN|TE), ADMSK=0x05, pulse ADC_Trigger -> commands for channels 0 then 2 in order. At end ADCS reads 0x15, ADC_Interrupt stays 0 (IE=0).
- Write ADCS IF=0 with IE=1 -> IF clears and ADC_Interrupt drops within 2 cycles. Write SC=1 with EN=0 -> no command issued, SC reads 0.
- ADMSK=0, write ADCS=0x0B -> no command; SC clears and IF sets within 2 cycles.
- Mid-scan write ADCS=0 -> ADC_C_Valid drops next cycle; a later response does not update ADCn.
